// File: rtl/resource_scheduler.sv
// Round-robin scheduler granting energy/tracer/fluid pool deductions per 3-bit web type.
// Define RESOURCE_STATS_EN to add the saturating o_deny_count statistics output.
module resource_scheduler #(
   parameter int unsigned ENERGY_INIT  = 200,
   parameter int unsigned TRACER_INIT  = 63,
   parameter int unsigned FLUID_INIT   = 15,
   parameter int unsigned REGEN_PERIOD = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] i_req,
   input  logic [8:0] i_req_type,
   input  logic       i_fluid_refill,
   output logic [2:0] o_ack,
   output logic       o_ack_ok,
   output logic       o_busy,
   output logic [7:0] o_energy_lvl,
   output logic [5:0] o_tracer_lvl,
   output logic [3:0] o_fluid_lvl
`ifdef RESOURCE_STATS_EN
   ,
   output logic [7:0] o_deny_count
`endif
);

   localparam int unsigned CntW = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(REGEN_PERIOD - 1);

   typedef enum logic [2:0] {StIdle, StCheck, StCommit, StDone, StRelease} state_e;

   function automatic logic [1:0] inc_mod3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   state_e          r_state;
   logic [1:0]      r_winner;
   logic [2:0]      r_type;
   logic            r_ok;
   logic [1:0]      r_rr_ptr;
   logic [2:0]      r_ack;
   logic            r_ack_ok;
   logic [7:0]      r_energy;
   logic [5:0]      r_tracer;
   logic [3:0]      r_fluid;
   logic [CntW-1:0] r_regen_cnt;
`ifdef RESOURCE_STATS_EN
   logic [7:0]      r_deny_cnt;
`endif

   logic [1:0] w_idx1;
   logic [1:0] w_idx2;
   logic       w_found;
   logic [1:0] w_win_idx;
   logic [2:0] w_win_type;
   logic [7:0] w_ecost;
   logic [3:0] w_fcost;
   logic [5:0] w_tcost;
   logic       w_tick;
   logic       w_commit;
   logic [8:0] w_energy_sum;
   logic [7:0] w_energy_nxt;
   logic [3:0] w_fluid_sub;

   assign w_idx1  = inc_mod3(r_rr_ptr);
   assign w_idx2  = inc_mod3(w_idx1);
   assign w_found = |i_req;

   // Search order starts at the round-robin pointer.
   always_comb begin
      w_win_idx = r_rr_ptr;
      if (i_req[r_rr_ptr]) begin
         w_win_idx = r_rr_ptr;
      end else if (i_req[w_idx1]) begin
         w_win_idx = w_idx1;
      end else if (i_req[w_idx2]) begin
         w_win_idx = w_idx2;
      end
   end

   always_comb begin
      case (w_win_idx)
         2'd0:    w_win_type = i_req_type[2:0];
         2'd1:    w_win_type = i_req_type[5:3];
         default: w_win_type = i_req_type[8:6];
      endcase
   end

   assign w_ecost  = {3'b000, r_type, 2'b00};
   assign w_fcost  = {2'b00, r_type[1:0]} + 4'd1;
   assign w_tcost  = {5'b00000, r_type[2]};
   assign w_tick   = (r_regen_cnt == CntMax);
   assign w_commit = (r_state == StCommit) && r_ok;

   // Deduction and regen combine in 9 bits; ok guarantees no underflow, so bit 8 means overflow.
   assign w_energy_sum = {1'b0, r_energy} - (w_commit ? {1'b0, w_ecost} : 9'd0)
                         + {8'd0, w_tick};
   assign w_energy_nxt = w_energy_sum[8] ? 8'hFF : w_energy_sum[7:0];
   assign w_fluid_sub  = (r_fluid >= w_fcost) ? (r_fluid - w_fcost) : 4'd0;

   always_ff @(posedge clk) begin
      if (reset || w_tick) begin
         r_regen_cnt <= '0;
      end else begin
         r_regen_cnt <= r_regen_cnt + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_energy <= 8'(ENERGY_INIT);
         r_tracer <= 6'(TRACER_INIT);
         r_fluid  <= 4'(FLUID_INIT);
      end else begin
         r_energy <= w_energy_nxt;
         if (w_commit) begin
            r_tracer <= r_tracer - w_tcost;
         end
         // A refill pulse overrides any fluid deduction in the same cycle.
         if (i_fluid_refill) begin
            r_fluid <= 4'(FLUID_INIT);
         end else if (w_commit) begin
            r_fluid <= w_fluid_sub;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StIdle;
         r_winner   <= 2'd0;
         r_type     <= 3'd0;
         r_ok       <= 1'b0;
         r_rr_ptr   <= 2'd0;
         r_ack      <= 3'b000;
         r_ack_ok   <= 1'b0;
`ifdef RESOURCE_STATS_EN
         r_deny_cnt <= 8'd0;
`endif
      end else begin
         r_ack    <= 3'b000;
         r_ack_ok <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_winner <= w_win_idx;
                  r_type   <= w_win_type;
                  r_state  <= StCheck;
               end
            end
            StCheck: begin
               r_ok    <= (r_energy >= w_ecost) && (r_tracer >= w_tcost) && (r_fluid >= w_fcost);
               r_state <= StCommit;
            end
            StCommit: begin
               r_state <= StDone;
            end
            StDone: begin
               r_ack    <= 3'b001 << r_winner;
               r_ack_ok <= r_ok;
               r_rr_ptr <= inc_mod3(r_winner);
`ifdef RESOURCE_STATS_EN
               if (!r_ok && (r_deny_cnt != 8'hFF)) begin
                  r_deny_cnt <= r_deny_cnt + 8'd1;
               end
`endif
               r_state  <= StRelease;
            end
            StRelease: begin
               if (!i_req[r_winner]) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_ack        = r_ack;
   assign o_ack_ok     = r_ack_ok;
   assign o_busy       = (r_state != StIdle);
   assign o_energy_lvl = r_energy;
   assign o_tracer_lvl = r_tracer;
   assign o_fluid_lvl  = r_fluid;
`ifdef RESOURCE_STATS_EN
   assign o_deny_count = r_deny_cnt;
`endif

endmodule

// File: tb/tb_resource_scheduler.sv
// Directed bench for resource_scheduler: three instances (default, regen held off, energy at 255).
module tb_resource_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] req = 3'b000;
   logic [8:0] req_type = 9'd0;
   logic       refill = 1'b0;

   logic [2:0] ack_m, ack_n, ack_s;
   logic       ok_m, ok_n, ok_s;
   logic       busy_m, busy_n, busy_s;
   logic [7:0] energy_m, energy_n, energy_s;
   logic [5:0] tracer_m, tracer_n, tracer_s;
   logic [3:0] fluid_m, fluid_n, fluid_s;
`ifdef RESOURCE_STATS_EN
   logic [7:0] deny_m, deny_n, deny_s;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   resource_scheduler dut_m (
      .clk(clk), .reset(reset), .i_req(req), .i_req_type(req_type), .i_fluid_refill(refill),
      .o_ack(ack_m), .o_ack_ok(ok_m), .o_busy(busy_m), .o_energy_lvl(energy_m),
      .o_tracer_lvl(tracer_m), .o_fluid_lvl(fluid_m)
`ifdef RESOURCE_STATS_EN
      , .o_deny_count(deny_m)
`endif
   );

   resource_scheduler #(.REGEN_PERIOD(255)) dut_n (
      .clk(clk), .reset(reset), .i_req(req), .i_req_type(req_type), .i_fluid_refill(refill),
      .o_ack(ack_n), .o_ack_ok(ok_n), .o_busy(busy_n), .o_energy_lvl(energy_n),
      .o_tracer_lvl(tracer_n), .o_fluid_lvl(fluid_n)
`ifdef RESOURCE_STATS_EN
      , .o_deny_count(deny_n)
`endif
   );

   resource_scheduler #(.ENERGY_INIT(255)) dut_s (
      .clk(clk), .reset(reset), .i_req(req), .i_req_type(req_type), .i_fluid_refill(refill),
      .o_ack(ack_s), .o_ack_ok(ok_s), .o_busy(busy_s), .o_energy_lvl(energy_s),
      .o_tracer_lvl(tracer_s), .o_fluid_lvl(fluid_s)
`ifdef RESOURCE_STATS_EN
      , .o_deny_count(deny_s)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = 3'b000;
      refill = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Raise one request, wait (bounded) for its ack on the chosen instance, then release it.
   task automatic do_req(input int idx, input logic [2:0] t, input int sel,
                         output logic [2:0] a, output logic k, output int lat);
      logic [2:0] a_now;
      logic       k_now;
      a = 3'b000;
      k = 1'b0;
      lat = -1;
      req_type[3*idx +: 3] = t;
      req[idx] = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         a_now = (sel == 1) ? ack_n : (sel == 2) ? ack_s : ack_m;
         k_now = (sel == 1) ? ok_n : (sel == 2) ? ok_s : ok_m;
         if (a_now != 3'b000) begin
            a = a_now;
            k = k_now;
            lat = c;
            break;
         end
      end
      req[idx] = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req = 3'b111;
      step();
      step();
      n_cmp++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_m); end
      n_cmp++; if (ack_m !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b want 000", ack_m); end
      n_cmp++; if (ok_m !== 1'b0) begin n_fail++; $display("FAIL reset_ack_ok: got %b want 0", ok_m); end
      n_cmp++; if (energy_m !== 8'd200) begin n_fail++; $display("FAIL reset_energy: got %0d want 200", energy_m); end
      n_cmp++; if (tracer_m !== 6'd63) begin n_fail++; $display("FAIL reset_tracer: got %0d want 63", tracer_m); end
      n_cmp++; if (fluid_m !== 4'd15) begin n_fail++; $display("FAIL reset_fluid: got %0d want 15", fluid_m); end
      req = 3'b000;
   endtask

   task automatic test_single();
      logic [2:0] a;
      logic       k;
      int         lat;
      do_reset();
      do_req(0, 3'd3, 0, a, k, lat);
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL single_latency: got %0d want 4", lat); end
      n_cmp++; if (a !== 3'b001) begin n_fail++; $display("FAIL single_ack: got %b want 001", a); end
      n_cmp++; if (k !== 1'b1) begin n_fail++; $display("FAIL single_ack_ok: got %b want 1", k); end
      n_cmp++; if (energy_m !== 8'd188) begin n_fail++; $display("FAIL single_energy: got %0d want 188", energy_m); end
      n_cmp++; if (fluid_m !== 4'd11) begin n_fail++; $display("FAIL single_fluid: got %0d want 11", fluid_m); end
      n_cmp++; if (tracer_m !== 6'd63) begin n_fail++; $display("FAIL single_tracer: got %0d want 63", tracer_m); end
      n_cmp++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy_m); end
   endtask

   task automatic test_deny();
      logic [2:0] a;
      logic       k;
      int         lat;
      logic [3:0] exp_fluid [4] = '{4'd11, 4'd7, 4'd3, 4'd3};
      logic [7:0] exp_energy [4] = '{8'd188, 8'd176, 8'd164, 8'd164};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         do_req(0, 3'd3, 1, a, k, lat);
         n_cmp++;
         if (k !== (i < 3)) begin
            n_fail++; $display("FAIL deny_ok[%0d]: got %b want %b", i, k, (i < 3));
         end
         n_cmp++;
         if (fluid_n !== exp_fluid[i]) begin
            n_fail++; $display("FAIL deny_fluid[%0d]: got %0d want %0d", i, fluid_n, exp_fluid[i]);
         end
         n_cmp++;
         if (energy_n !== exp_energy[i]) begin
            n_fail++; $display("FAIL deny_energy[%0d]: got %0d want %0d", i, energy_n, exp_energy[i]);
         end
      end
      // Type 2 costs exactly the remaining 3 fluid.
      do_req(0, 3'd2, 1, a, k, lat);
      n_cmp++; if (k !== 1'b1) begin n_fail++; $display("FAIL exact_ok: got %b want 1", k); end
      n_cmp++; if (fluid_n !== 4'd0) begin n_fail++; $display("FAIL exact_fluid: got %0d want 0", fluid_n); end
      n_cmp++; if (energy_n !== 8'd156) begin n_fail++; $display("FAIL exact_energy: got %0d want 156", energy_n); end
      do_req(0, 3'd0, 1, a, k, lat);
      n_cmp++; if (k !== 1'b0) begin n_fail++; $display("FAIL empty_ok: got %b want 0", k); end
      n_cmp++; if (fluid_n !== 4'd0) begin n_fail++; $display("FAIL empty_fluid: got %0d want 0", fluid_n); end
`ifdef RESOURCE_STATS_EN
      n_cmp++; if (deny_n !== 8'd2) begin n_fail++; $display("FAIL deny_count: got %0d want 2", deny_n); end
`endif
   endtask

   task automatic test_round_robin();
      logic [2:0] order [3];
      logic [2:0] oks;
      int         got;
      logic [2:0] exp_order [3] = '{3'b001, 3'b010, 3'b100};
      do_reset();
      got = 0;
      oks = 3'b000;
      req_type = 9'd0;
      req = 3'b111;
      for (int c = 0; c < 40 && got < 3; c++) begin
         step();
         if (ack_m != 3'b000) begin
            order[got] = ack_m;
            oks[got] = ok_m;
            got++;
            req = req & ~ack_m;
         end
      end
      step();
      n_cmp++; if (got !== 3) begin n_fail++; $display("FAIL rr_count: got %0d want 3", got); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (i < got && order[i] !== exp_order[i]) begin
            n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", i, order[i], exp_order[i]);
         end
      end
      n_cmp++; if (oks !== 3'b111) begin n_fail++; $display("FAIL rr_oks: got %b want 111", oks); end
      n_cmp++; if (fluid_m !== 4'd12) begin n_fail++; $display("FAIL rr_fluid: got %0d want 12", fluid_m); end
      req = 3'b000;
   endtask

   task automatic test_regen();
      do_reset();
      repeat (15) step();
      n_cmp++; if (energy_m !== 8'd200) begin n_fail++; $display("FAIL regen_15: got %0d want 200", energy_m); end
      step();
      n_cmp++; if (energy_m !== 8'd201) begin n_fail++; $display("FAIL regen_16: got %0d want 201", energy_m); end
      n_cmp++; if (energy_s !== 8'd255) begin n_fail++; $display("FAIL regen_sat16: got %0d want 255", energy_s); end
      repeat (16) step();
      n_cmp++; if (energy_m !== 8'd202) begin n_fail++; $display("FAIL regen_32: got %0d want 202", energy_m); end
      n_cmp++; if (energy_s !== 8'd255) begin n_fail++; $display("FAIL regen_sat32: got %0d want 255", energy_s); end
   endtask

   task automatic test_regen_commit();
      logic [2:0] a;
      logic       k;
      int         lat;
      do_reset();
      repeat (13) step();
      // Sampled at edge 14, so COMMIT lands on the regen tick at edge 16.
      do_req(0, 3'd3, 0, a, k, lat);
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL rc_latency: got %0d want 4", lat); end
      n_cmp++; if (energy_m !== 8'd189) begin n_fail++; $display("FAIL rc_energy: got %0d want 189", energy_m); end
   endtask

   task automatic test_refill_commit();
      do_reset();
      req_type = 9'd7;
      req = 3'b001;
      step();
      req_type = 9'd0;
      step();
      refill = 1'b1;
      step();
      refill = 1'b0;
      step();
      n_cmp++; if (ack_m !== 3'b001) begin n_fail++; $display("FAIL refill_ack: got %b want 001", ack_m); end
      n_cmp++; if (ok_m !== 1'b1) begin n_fail++; $display("FAIL refill_ack_ok: got %b want 1", ok_m); end
      req = 3'b000;
      step();
      n_cmp++; if (energy_m !== 8'd172) begin n_fail++; $display("FAIL refill_energy: got %0d want 172", energy_m); end
      n_cmp++; if (fluid_m !== 4'd15) begin n_fail++; $display("FAIL refill_fluid: got %0d want 15", fluid_m); end
      n_cmp++; if (tracer_m !== 6'd62) begin n_fail++; $display("FAIL refill_tracer: got %0d want 62", tracer_m); end
   endtask

   task automatic test_reset_mid();
      logic [2:0] a;
      logic       k;
      int         lat;
      logic       saw_ack;
      do_reset();
      do_req(0, 3'd3, 0, a, k, lat);
      n_cmp++; if (energy_m !== 8'd188) begin n_fail++; $display("FAIL mid_pre_energy: got %0d want 188", energy_m); end
      req_type = 9'd3;
      req = 3'b001;
      step();
      step();
      n_cmp++; if (busy_m !== 1'b1) begin n_fail++; $display("FAIL mid_busy_commit: got %b want 1", busy_m); end
      reset = 1'b1;
      req = 3'b000;
      step();
      n_cmp++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy_m); end
      n_cmp++; if (ack_m !== 3'b000) begin n_fail++; $display("FAIL mid_ack: got %b want 000", ack_m); end
      n_cmp++; if (energy_m !== 8'd200) begin n_fail++; $display("FAIL mid_energy: got %0d want 200", energy_m); end
      n_cmp++; if (tracer_m !== 6'd63) begin n_fail++; $display("FAIL mid_tracer: got %0d want 63", tracer_m); end
      n_cmp++; if (fluid_m !== 4'd15) begin n_fail++; $display("FAIL mid_fluid: got %0d want 15", fluid_m); end
      reset = 1'b0;
      saw_ack = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (ack_m != 3'b000) saw_ack = 1'b1;
      end
      n_cmp++; if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL mid_late_ack: got %b want 0", saw_ack); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_deny();
      test_round_robin();
      test_regen();
      test_regen_commit();
      test_refill_commit();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
